// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, controller states and reset constants for iter_mdu
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_UMULL = 3'd1,
    OP_SMULL = 3'd2,
    OP_UDIV  = 3'd3,
    OP_SDIV  = 3'd4
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
  localparam state_e RST_STATE = S_IDLE;
  localparam logic   RST_FLAG  = 1'b0;
  function automatic logic is_div(input logic [2:0] o);
    return o == OP_UDIV || o == OP_SDIV;
  endfunction
  function automatic logic is_signed_op(input logic [2:0] o);
    return o == OP_SMULL || o == OP_SDIV;
  endfunction
  function automatic logic is_rsvd(input logic [2:0] o);
    return o > OP_SDIV;
  endfunction
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: N-bit add or subtract with carry-out (carry=1 on subtract means no borrow)
module mdu_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, x} + {1'b0, sub ? ~y : y} + (N+1)'(sub);
endmodule

// File: rtl/iter_mdu.sv
// iter_mdu: iterative radix-2 multiply/divide unit, one step per clock
module iter_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [WIDTH-1:0] hi, lo, m, hi_n, lo_n, a_mag, b_mag, quo, rem;
  logic [WIDTH:0] x, s, t;
  logic [2*WIDTH-1:0] prod;
  logic co, div_op, last, neg_q, rneg_q, sgn_in, dz_in, skip_in;
  assign div_op  = is_div(op_q);
  assign last    = cnt == CW'(WIDTH - 1);
  assign sgn_in  = is_signed_op(op);
  assign dz_in   = is_div(op) && b == '0;
  assign skip_in = is_rsvd(op) || dz_in;
  assign a_mag   = sgn_in && a[WIDTH-1] ? -a : a;
  assign b_mag   = sgn_in && b[WIDTH-1] ? -b : b;
  assign x       = div_op ? {hi, lo[WIDTH-1]} : {1'b0, hi};
  assign busy    = state != S_IDLE;
  assign done    = state == S_DONE;
  mdu_addsub #(.N(WIDTH + 1)) u_addsub (
    .x  (x),
    .y  ({1'b0, m}),
    .sub(div_op),
    .s  (s),
    .co (co)
  );
  // one shift-add (multiply) or restoring shift-subtract (divide) step, plus sign fix-up of the final step
  always_comb begin
    t    = div_op ? (co ? s : x) : (lo[0] ? s : {1'b0, hi});
    hi_n = div_op ? t[WIDTH-1:0] : t[WIDTH:1];
    lo_n = div_op ? {lo[WIDTH-2:0], co} : {t[0], lo[WIDTH-1:1]};
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo  = neg_q ? -lo_n : lo_n;
    rem  = rneg_q ? -hi_n : hi_n;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= RST_STATE;
    else       state <= state_n;
  end
  // next state: reserved ops and divide-by-zero jump straight to DONE
  always_comb begin
    state_n = state;
    if (state == S_IDLE)     state_n = start ? (skip_in ? S_DONE : S_RUN) : S_IDLE;
    else if (state == S_RUN) state_n = last ? S_DONE : S_RUN;
    else                     state_n = S_IDLE;
  end
  // operand latch, iteration datapath and result registers (written only on entry to DONE)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      op_q        <= '0;
      hi          <= '0;
      lo          <= '0;
      m           <= '0;
      neg_q       <= RST_FLAG;
      rneg_q      <= RST_FLAG;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= RST_FLAG;
    end else if (state == S_IDLE && start) begin
      cnt    <= '0;
      op_q   <= op;
      hi     <= '0;
      lo     <= is_div(op) ? a_mag : b_mag;
      m      <= is_div(op) ? b_mag : a_mag;
      neg_q  <= sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q <= sgn_in && a[WIDTH-1];
      if (skip_in) begin
        result_lo   <= '0;
        result_hi   <= dz_in ? a : '0;
        div_by_zero <= dz_in;
      end
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
      hi  <= hi_n;
      lo  <= lo_n;
      if (last) begin
        result_lo   <= div_op ? quo : prod[WIDTH-1:0];
        result_hi   <= div_op ? rem : (op_q == OP_MUL ? '0 : prod[2*WIDTH-1:WIDTH]);
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: doc/iter_mdu.md
ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, meaning operand and per-half result width; legal values are even integers from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 3 bits: operation select, sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start; a is multiplicand or dividend, b is multiplier or divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (state RUN or DONE).
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have ports result_lo and result_hi, output, WIDTH bits each: low and high result halves, registered.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: qualifies the current results; valid whenever done is high and held until the next accepted start.

Function
REQ-011 Op encodings SHALL be: 000 MUL (lo only, hi=0); 001 UMULL; 010 SMULL; 011 UDIV (lo=quotient, hi=remainder); 100 SDIV; 101-111 reserved.
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE, the block SHALL accept start=1 at a clock edge, latch op, a and b, clear the iteration counter and enter RUN.
REQ-014 RUN SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) for exactly WIDTH cycles, then enter DONE.
REQ-015 DONE SHALL last one cycle, with done=1, and then return to IDLE.
REQ-016 done SHALL therefore be high exactly WIDTH+1 edges after the edge that accepted start.
REQ-017 start SHALL be ignored in RUN and DONE; a new start is accepted on the first edge spent in IDLE, which allows back-to-back operations with one idle cycle.
REQ-018 result_lo, result_hi and div_by_zero SHALL update only on entry to DONE and hold their values through IDLE until the next operation reaches DONE.
REQ-019 Signed ops SHALL operate on operand magnitudes and apply the sign afterwards, as follows.
  - SMULL: the product sign is a[WIDTH-1] XOR b[WIDTH-1].
  - SDIV quotient: truncates toward zero.
  - SDIV remainder: takes the sign of the dividend.
REQ-020 For SDIV of the most-negative value by -1, the block SHALL return quotient = most-negative value and remainder = 0, with no flag set.
REQ-021 For UDIV or SDIV with b=0, the block SHALL skip RUN and go IDLE→DONE in one cycle, returning quotient=0, remainder=a and div_by_zero=1.
REQ-022 A reserved op SHALL skip RUN, with DONE one edge after start, results 0 and div_by_zero=0.
REQ-023 div_by_zero SHALL be 0 for every multiply op.
REQ-024 MUL SHALL return the low WIDTH bits of the unsigned product, which are identical to the low bits of the signed product.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set state=IDLE, counter=0, busy=0, done=0, result_lo=0, result_hi=0 and div_by_zero=0.
REQ-026 Reset SHALL override start on the same edge.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse, and the results SHALL read 0 afterwards.

Structure
REQ-028 Op encodings, the state enumeration and the reset constants SHALL live in shared package mdu_pkg, for use by the controller decode.
REQ-029 One sub-module, mdu_addsub, SHALL provide the (WIDTH+1)-bit add/subtract with carry-out and be shared by the multiply and divide step logic.
REQ-030 The iteration counter SHALL be clog2(WIDTH+1) bits wide.
REQ-031 No combinational path SHALL exist from start, op, a or b to any output.

Verification
REQ-032 The bench SHALL run these directed scenarios at WIDTH=32, each expressed as stimulus -> required response.
  - UMULL, a=0xFFFFFFFF, b=0xFFFFFFFF -> 33 edges after start: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for those 33 cycles.
  - SMULL, a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; then MUL with the same operands -> lo=0xFFFFFFFA, hi=0.
  - SDIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; SDIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
  - UDIV, a=100, b=0 -> done one edge after start, lo=0, hi=100, div_by_zero=1; the following UDIV 100/7 -> lo=14, hi=2, div_by_zero=0.
  - Start pulsed again 5 cycles into a UMULL, with different operands -> ignored; the original result is produced and the completion edge count is unchanged.
  - Reset asserted 10 cycles into a UDIV -> next cycle busy=0, no done pulse, all results 0; a new start on the following edge completes normally.
